crc_stream_engine: RTL and testbench
====================================

// Module: crc_stream_engine
// PURPOSE
//  Parametrised streaming CRC generator/checker. Bit-serial, MSB-first LFSR (one bit per clk).
//  Computes CRC over a multi-word frame delimited by in_last. Polynomial is run-time programmable.
//  Check mode compares the final CRC to a reference value; a saturating counter tallies failures.
//  Successor to the fixed 32-bit generate/check pair. Sits between the frame source and the link/checker logic.
// PARAMETERS
//  CRC_W    32            CRC width (bits), >=4
//  DATA_W   32            input word width (bits), >=1
//  INIT     {CRC_W{1'b1}} CRC register value loaded at frame start
//  XOR_OUT  {CRC_W{1'b1}} value XORed into the final remainder
//  CNT_W    8             error counter width
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active-high
//  mode_i     in   1       0 = generate, 1 = check; sampled on first beat of frame
//  polynom_i  in   CRC_W   polynomial without implicit x^CRC_W term; sampled on first beat
//  in_valid   in   1       input word valid
//  in_ready   out  1       engine can accept a word
//  in_data    in   DATA_W  input word, MSB processed first
//  in_last    in   1       word is last of frame
//  crc_ref_i  in   CRC_W   expected CRC; sampled on the last beat (check mode)
//  out_valid  out  1       result valid
//  out_ready  in   1       result consumed
//  crc_o      out  CRC_W   final CRC (remainder ^ XOR_OUT)
//  crc_ok_o   out  1       check mode: crc_o == captured ref; generate mode: 1
//  err_cnt_o  out  CNT_W   saturating count of failed checks
//  busy_o     out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at posedge) dominates everything:
//    - state=IDLE, first=1, in_ready=1, out_valid=0, crc_o=0, crc_ok_o=0, err_cnt_o=0, busy_o=0.
//    - Reset mid-frame discards the frame; no result is emitted.
//  - FSM IDLE/SHIFT/DONE. in_ready = (state==IDLE); all outputs are registered.
//  - IDLE, accept on in_valid&&in_ready:
//    - latch in_data and in_last; bit counter = DATA_W-1.
//    - if first=1: crc = INIT, and latch mode_i and polynom_i; first <= 0.
//    - -> SHIFT.
//  - SHIFT, once per clk on bit b = word[cnt]:
//    - fb = crc[CRC_W-1]^b; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? poly : 0).
//    - cnt decrements. After DATA_W shifts: last ? DONE : IDLE.
//  - Timing:
//    - A word occupies DATA_W+1 clks, accept cycle included. Max rate is 1 word per DATA_W+1 clks.
//    - out_valid rises DATA_W clks after the accept edge of the last word.
//  - Entry to DONE:
//    - crc_o = crc ^ XOR_OUT.
//    - crc_ok_o = mode ? (crc_o == ref) : 1.
//    - if mode && !ok: err_cnt_o++, saturating at 2^CNT_W-1 (no wrap).
//  - DONE:
//    - out_valid, crc_o and crc_ok_o are held stable until out_ready.
//    - on out_valid&&out_ready: out_valid=0, first=1, -> IDLE. in_ready rises the following cycle.
//    - in_ready stays 0 in DONE (backpressure); crc_o keeps its value after handshake.
//  - Single-word frame (in_last on first beat) is legal; INIT and poly apply.
//  - Frame-boundary sampling:
//    - mode_i and polynom_i changes mid-frame are ignored until the next first beat.
//    - crc_ref_i is sampled only with in_last.
//  - in_valid with in_ready=0 is a stall; the source holds the word stable.
// TESTING
//  1. DATA_W=8, CRC_W=32, poly 04C11DB7, defaults. Generate mode, bytes 0x31..0x39, in_last on 0x39.
//     -> crc_o=FC891918, crc_ok_o=1. out_valid rises 80 clks after the first accept (9 words x 9 clks, less 1).
//  2. Same frame, XOR_OUT=0 -> crc_o=0376E6E7.
//  3. Check mode, case-1 frame:
//     - crc_ref_i=FC891918 -> crc_ok_o=1, err_cnt_o=0.
//     - then crc_ref_i=FC891919 -> crc_ok_o=0, err_cnt_o=1.
//  4. CNT_W=2, 5 failing check frames -> err_cnt_o 1,2,3,3,3 (saturates).
//  5. out_ready=0 for 20 clks after out_valid:
//     - crc_o stable, in_ready=0.
//     - release -> one handshake; the next frame reloads INIT (case-1 repeated gives FC891918 again).
//  6. rst=1 during the 4th byte of case 1 -> all outputs at reset values.
//     Then a full case-1 frame -> FC891918 (no residue).

Source files
------------

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: bit-serial, MSB-first streaming CRC generator/checker.
// A frame is one or more words delimited by in_last. Each word is shifted
// through the LFSR one bit per clock. The final remainder is XORed with
// XOR_OUT. In check mode the result is compared against a reference value,
// and a saturating counter tallies the failed checks.
module crc_stream_engine #(
  parameter int               CRC_W   = 32,
  parameter int               DATA_W  = 32,
  parameter logic [CRC_W-1:0] INIT    = {CRC_W{1'b1}},
  parameter logic [CRC_W-1:0] XOR_OUT = {CRC_W{1'b1}},
  parameter int               CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_i,
  input  logic [CRC_W-1:0]  polynom_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [CRC_W-1:0]  crc_ref_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_o,
  output logic              crc_ok_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              busy_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One LFSR step: feedback is the CRC MSB XOR the incoming data bit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic             bit_in,
                                                input logic [CRC_W-1:0] poly);
    logic fb;
    fb = crc[CRC_W-1] ^ bit_in;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic                first_r;
  logic                mode_r;
  logic [CRC_W-1:0]    poly_r;
  logic [CRC_W-1:0]    crc_r;
  logic [CRC_W-1:0]    ref_r;
  logic [DATA_W-1:0]   word_r;
  logic                last_r;
  logic [IDX_W-1:0]    cnt_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [CRC_W-1:0]    crc_out_r;
  logic                crc_ok_r;
  logic [CNT_W-1:0]    err_cnt_r;
  logic                busy_r;

  logic                accept_s;
  logic                last_bit_s;
  logic [CRC_W-1:0]    crc_step_s;
  logic [CRC_W-1:0]    crc_final_s;
  logic                crc_ok_s;

  // Datapath helpers: handshake, next LFSR value and the finished result.
  always_comb begin
    accept_s    = in_valid && in_ready_r;
    last_bit_s  = (cnt_r == {IDX_W{1'b0}});
    crc_step_s  = crc_step(crc_r, word_r[DATA_W-1], poly_r);
    crc_final_s = crc_step_s ^ XOR_OUT;
    if (mode_r) begin
      crc_ok_s = (crc_final_s == ref_r);
    end else begin
      crc_ok_s = 1'b1;
    end
  end

  // Next-state logic for the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          state_next_s = last_r ? ST_DONE : ST_IDLE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame capture, LFSR shifting, result registers and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r     <= 1'b1;
      mode_r      <= 1'b0;
      poly_r      <= {CRC_W{1'b0}};
      crc_r       <= {CRC_W{1'b0}};
      ref_r       <= {CRC_W{1'b0}};
      word_r      <= {DATA_W{1'b0}};
      last_r      <= 1'b0;
      cnt_r       <= {IDX_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      crc_out_r   <= {CRC_W{1'b0}};
      crc_ok_r    <= 1'b0;
      err_cnt_r   <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            word_r <= in_data;
            last_r <= in_last;
            cnt_r  <= IDX_W'(DATA_W - 1);
            // Mode and polynomial are frozen for the whole frame.
            if (first_r) begin
              crc_r   <= INIT;
              mode_r  <= mode_i;
              poly_r  <= polynom_i;
              first_r <= 1'b0;
            end
            if (in_last) begin
              ref_r <= crc_ref_i;
            end
          end
        end
        ST_SHIFT: begin
          crc_r  <= crc_step_s;
          word_r <= word_r << 1;
          cnt_r  <= cnt_r - IDX_W'(1);
          if (last_bit_s && last_r) begin
            crc_out_r   <= crc_final_s;
            crc_ok_r    <= crc_ok_s;
            out_valid_r <= 1'b1;
            if (mode_r && !crc_ok_s) begin
              err_cnt_r <= sat_inc(err_cnt_r);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            first_r     <= 1'b1;
          end
        end
        default: begin
          first_r <= 1'b1;
        end
      endcase
      in_ready_r <= (state_next_s == ST_IDLE);
      busy_r     <= (state_next_s != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign crc_o     = crc_out_r;
  assign crc_ok_o  = crc_ok_r;
  assign err_cnt_o = err_cnt_r;
  assign busy_o    = busy_r;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed testbench for crc_stream_engine using the "123456789" CRC-32/BZIP2 vector.
// Instance a: defaults with DATA_W=8. Instance b: XOR_OUT=0. Instance c: CNT_W=2.
module tb_crc_stream_engine;

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_STD = 32'hFC891918;
  localparam logic [31:0] CRC_RAW = 32'h0376E6E7;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_i;
  logic [31:0] polynom_i;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic [31:0] crc_ref_i;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_ok, a_busy;
  logic [31:0] a_crc;
  logic [7:0]  a_err;
  logic        b_in_ready, b_out_valid, b_ok, b_busy;
  logic [31:0] b_crc;
  logic [7:0]  b_err;
  logic        c_in_ready, c_out_valid, c_ok, c_busy;
  logic [31:0] c_crc;
  logic [1:0]  c_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;
  int t1     = 0;
  logic [7:0] msg [0:8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  crc_stream_engine #(.CRC_W(32), .DATA_W(8)) u_a (
    .clk(clk), .rst(rst), .mode_i(mode_i), .polynom_i(polynom_i),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
    .crc_ref_i(crc_ref_i), .out_valid(a_out_valid), .out_ready(out_ready),
    .crc_o(a_crc), .crc_ok_o(a_ok), .err_cnt_o(a_err), .busy_o(a_busy));

  crc_stream_engine #(.CRC_W(32), .DATA_W(8), .XOR_OUT(32'h0)) u_b (
    .clk(clk), .rst(rst), .mode_i(mode_i), .polynom_i(polynom_i),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
    .crc_ref_i(crc_ref_i), .out_valid(b_out_valid), .out_ready(out_ready),
    .crc_o(b_crc), .crc_ok_o(b_ok), .err_cnt_o(b_err), .busy_o(b_busy));

  crc_stream_engine #(.CRC_W(32), .DATA_W(8), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .mode_i(mode_i), .polynom_i(polynom_i),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data), .in_last(in_last),
    .crc_ref_i(crc_ref_i), .out_valid(c_out_valid), .out_ready(out_ready),
    .crc_o(c_crc), .crc_ok_o(c_ok), .err_cnt_o(c_err), .busy_o(c_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; mode/poly/ref are scrambled off their sampling beats.
  task automatic send_word(input logic [7:0] d, input logic last, input logic md,
                           input logic [31:0] rf, input logic first_beat);
    int n;
    n = 0;
    while (!a_in_ready && n < 100) begin
      step();
      n++;
    end
    if (!a_in_ready) check("ready_timeout", {31'd0, a_in_ready}, 32'd1);
    in_data   = d;
    in_last   = last;
    in_valid  = 1'b1;
    mode_i    = first_beat ? md : ~md;
    polynom_i = first_beat ? POLY : 32'hDEADBEEF;
    crc_ref_i = last ? rf : ~rf;
    step();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic send_frame(input logic md, input logic [31:0] rf, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      send_word(msg[i], (i == 8), md, rf, (i == 0));
      if (i == 0) t0 = cyc;
    end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!a_out_valid && n < 200) begin
      step();
      n++;
    end
    t1 = cyc;
    check("result_valid", {31'd0, a_out_valid}, 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hs_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("hs_in_ready", {31'd0, a_in_ready}, 32'd1);
  endtask

  initial begin
    msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34; msg[4] = 8'h35;
    msg[5] = 8'h36; msg[6] = 8'h37; msg[7] = 8'h38; msg[8] = 8'h39;
    rst = 1'b1; mode_i = 1'b0; polynom_i = POLY; in_valid = 1'b0;
    in_data = 8'h00; in_last = 1'b0; crc_ref_i = 32'h0; out_ready = 1'b0;
    repeat (2) step();

    check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_crc", a_crc, 32'h0);
    check("rst_ok", {31'd0, a_ok}, 32'd0);
    check("rst_err", {24'd0, a_err}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    rst = 1'b0;
    step();

    // Generate mode, standard vector, plus latency.
    send_frame(1'b0, 32'h0, 9);
    wait_result();
    check("gen_latency", t1 - t0, 32'd80);
    check("gen_crc", a_crc, CRC_STD);
    check("gen_ok", {31'd0, a_ok}, 32'd1);
    check("noxor_crc", b_crc, CRC_RAW);
    check("done_busy", {31'd0, a_busy}, 32'd1);
    check("done_in_ready", {31'd0, a_in_ready}, 32'd0);
    handshake();
    check("post_hs_crc_kept", a_crc, CRC_STD);

    // Check mode, matching reference.
    send_frame(1'b1, CRC_STD, 9);
    wait_result();
    check("chk_pass_ok", {31'd0, a_ok}, 32'd1);
    check("chk_pass_err", {24'd0, a_err}, 32'd0);
    handshake();

    // Check mode, wrong reference.
    send_frame(1'b1, 32'hFC891919, 9);
    wait_result();
    check("chk_fail_ok", {31'd0, a_ok}, 32'd0);
    check("chk_fail_err", {24'd0, a_err}, 32'd1);
    check("sat_err_1", {30'd0, c_err}, 32'd1);
    handshake();

    // More failing frames: the 2-bit counter saturates at 3.
    for (int k = 2; k <= 5; k++) begin
      send_frame(1'b1, 32'hFC891919, 9);
      wait_result();
      check("sat_err", {30'd0, c_err}, (k > 3) ? 32'd3 : 32'(k));
      handshake();
    end
    check("err_cnt_wide", {24'd0, a_err}, 32'd5);

    // Backpressure: result held for 20 clocks.
    send_frame(1'b0, 32'h0, 9);
    wait_result();
    for (int k = 0; k < 20; k++) begin
      check("bp_crc", a_crc, CRC_STD);
      check("bp_out_valid", {31'd0, a_out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
      step();
    end
    handshake();
    send_frame(1'b0, 32'h0, 9);
    wait_result();
    check("reload_crc", a_crc, CRC_STD);
    handshake();

    // Reset while shifting the 4th byte.
    send_frame(1'b0, 32'h0, 4);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("mid_rst_crc", a_crc, 32'h0);
    check("mid_rst_ok", {31'd0, a_ok}, 32'd0);
    check("mid_rst_err", {24'd0, a_err}, 32'd0);
    check("mid_rst_err_c", {30'd0, c_err}, 32'd0);
    check("mid_rst_busy", {31'd0, a_busy}, 32'd0);
    repeat (20) step();
    check("no_result_after_rst", {31'd0, a_out_valid}, 32'd0);
    send_frame(1'b0, 32'h0, 9);
    wait_result();
    check("post_rst_crc", a_crc, CRC_STD);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
